// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and defaults for the serial transmitter/receiver pair
package serial_pkg;

    localparam int OVS_DEFAULT    = 16;
    localparam int DVSR_W_DEFAULT = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running oversampling tick generator, one tick every dvsr_i+1 clocks
module baud_tick_gen
    import serial_pkg::*;
#(
    parameter int DVSR_W = DVSR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    output logic              tick_o
);

    logic [DVSR_W-1:0] cnt_q;

    // Count 0..dvsr_i; a count stranded above a lowered divisor wraps silently
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_q >= dvsr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DVSR_W'(1);
        end
    end

    assign tick_o = (cnt_q == dvsr_i);

endmodule

// File: rtl/rx_serial.sv
// rtl/rx_serial.sv - 16x oversampled serial receiver; RX_SERIAL_PARITY_EN adds an even-parity bit
module rx_serial
    import serial_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DVSR_W = DVSR_W_DEFAULT,
    parameter int OVS    = OVS_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              frame_err_o
);

    localparam int SW = $clog2(OVS);
    localparam int NW = $clog2(DATA_W);
    localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_W - 1);

    logic              tick;
    logic [1:0]        sync_q;
    logic              rx_s;
    rx_state_t         state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              frame_ok;
`ifdef RX_SERIAL_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    baud_tick_gen #(
        .DVSR_W (DVSR_W)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .dvsr_i (dvsr_i),
        .tick_o (tick)
    );

    // Two-flop synchroniser, idle-high so reset never fakes a start edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s = sync_q[1];

`ifdef RX_SERIAL_PARITY_EN
    assign frame_ok = rx_s && !par_err_q;
`else
    assign frame_ok = rx_s;
`endif

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef RX_SERIAL_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef RX_SERIAL_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // Deframing: align to start-bit middle, then sample once per bit period
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef RX_SERIAL_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
`ifdef RX_SERIAL_PARITY_EN
                            par_err_d = 1'b0;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        shreg_d = {rx_s, shreg_q[DATA_W-1:1]};
                        s_d     = '0;
                        if (n_q == N_LAST) begin
                            n_d = '0;
`ifdef RX_SERIAL_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`ifdef RX_SERIAL_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        par_err_d = ^{shreg_q, rx_s};
                        s_d       = '0;
                        state_d   = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        if (frame_ok) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        s_d     = '0;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_rx_serial.sv
// tb/tb_rx_serial.sv - self-checking bench for rx_serial with a behavioural serial transmitter
module tb_rx_serial;

    localparam int OVS = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [10:0] dvsr_i = 11'd6;
    logic        rx_i = 1'b1;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        busy_o;
    logic        frame_err_o;

    rx_serial dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .dvsr_i      (dvsr_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation side
    logic [7:0] got_q[$];
    int         got_t[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         dbl_cnt = 0;
    int         busy_low_cnt = 0;
    bit         busy_watch = 1'b0;
    bit         prev_valid = 1'b0;

    always @(negedge clk) begin
        if (valid_o) begin
            got_q.push_back(data_o);
            got_t.push_back(cyc);
        end
        if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
        if (valid_o && frame_err_o) both_cnt <= both_cnt + 1;
        if (valid_o && prev_valid) dbl_cnt <= dbl_cnt + 1;
        prev_valid <= valid_o;
        if (busy_watch && !busy_o) busy_low_cnt <= busy_low_cnt + 1;
    end

    // Reference model: a frame delivers its word iff stop and parity are good
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    logic [7:0] last_good = 8'h00;
    int         start_cyc = 0;
    int         n_cmp = 0;
    int         n_mis = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip, input bit watch);
        bit bits[$];
        int bc;
        int nb;
        bit v;
        bit par_ok;
        bc = (int'(dvsr_i) + 1) * OVS;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef RX_SERIAL_PARITY_EN
        bits.push_back((^d) ^ par_flip);
        par_ok = !par_flip;
`else
        par_ok = 1'b1;
`endif
        bits.push_back(stop_bit);
        nb = bits.size();
        start_cyc = cyc;
        for (int k = 0; k < nb * bc; k++) begin
            v = bits[k / bc];
            if ((k / bc) == nb - 1 && !stop_bit && (k % bc) >= (3 * bc) / 4) v = 1'b1;
            rx_i = v;
            busy_watch = watch && (k >= 3) && (k < (nb - 1) * bc + bc / 4);
            step();
        end
        busy_watch = 1'b0;
        rx_i = 1'b1;
        if (stop_bit && par_ok) begin
            exp_q.push_back(d);
            last_good = d;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        rx_i = 1'b1;
        dvsr_i = 11'd6;
        repeat (5) step();
        @(negedge clk);
        n_cmp++; if (data_o !== 8'h00) begin n_mis++; $display("FAIL reset_data got %h want 00", data_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_mis++; $display("FAIL reset_valid got %b want 0", valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_mis++; $display("FAIL reset_ferr got %b want 0", frame_err_o); end
        step();
        rst_i = 1'b0;
        repeat (200) step();
        n_cmp++; if (got_q.size() !== 0) begin n_mis++; $display("FAIL idle_valid got %0d pulses want 0", got_q.size()); end
        n_cmp++; if (ferr_cnt !== 0) begin n_mis++; $display("FAIL idle_ferr got %0d pulses want 0", ferr_cnt); end
    endtask

    task automatic test_single_a5();
        int bl0;
        int lat;
        int exp_lat;
        got_q.delete(); got_t.delete(); exp_q.delete();
        bl0 = busy_low_cnt;
        dvsr_i = 11'd6;
`ifdef RX_SERIAL_PARITY_EN
        exp_lat = 1066 + 112;
`else
        exp_lat = 1066;
`endif
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (20) step();
        n_cmp++; if (got_q.size() !== 1) begin n_mis++; $display("FAIL a5_count got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            lat = got_t[0] - start_cyc;
            n_cmp++; if (got_q[0] !== 8'hA5) begin n_mis++; $display("FAIL a5_data got %h want a5", got_q[0]); end
            n_cmp++; if (lat < exp_lat - 10 || lat > exp_lat + 10) begin n_mis++; $display("FAIL a5_latency got %0d want %0d+-10", lat, exp_lat); end
        end
        n_cmp++; if (busy_low_cnt - bl0 !== 0) begin n_mis++; $display("FAIL a5_busy got %0d low cycles want 0", busy_low_cnt - bl0); end
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL a5_busy_after got %b want 0", busy_o); end
    endtask

    task automatic test_loopback();
        int fe0;
        got_q.delete(); exp_q.delete();
        fe0 = ferr_cnt;
        dvsr_i = 11'd6;
        for (int i = 0; i < 10; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        repeat (20) step();
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL loop_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL loop_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (ferr_cnt - fe0 !== 0) begin n_mis++; $display("FAIL loop_ferr got %0d want 0", ferr_cnt - fe0); end
    endtask

    task automatic test_glitch();
        int fe0;
        got_q.delete();
        fe0 = ferr_cnt;
        dvsr_i = 11'd6;
        rx_i = 1'b0;
        repeat (40) step();
        rx_i = 1'b1;
        repeat (200) step();
        n_cmp++; if (got_q.size() !== 0) begin n_mis++; $display("FAIL glitch_valid got %0d want 0", got_q.size()); end
        n_cmp++; if (ferr_cnt - fe0 !== 0) begin n_mis++; $display("FAIL glitch_ferr got %0d want 0", ferr_cnt - fe0); end
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL glitch_busy got %b want 0", busy_o); end
    endtask

    task automatic test_stop_err();
        int fe0;
        int ef0;
        logic [7:0] prev;
        got_q.delete(); exp_q.delete();
        fe0 = ferr_cnt;
        ef0 = exp_ferr;
        prev = last_good;
        dvsr_i = 11'd6;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (224) step();
        n_cmp++; if (ferr_cnt - fe0 !== exp_ferr - ef0) begin n_mis++; $display("FAIL stop_ferr got %0d want %0d", ferr_cnt - fe0, exp_ferr - ef0); end
        n_cmp++; if (got_q.size() !== 0) begin n_mis++; $display("FAIL stop_valid got %0d want 0", got_q.size()); end
        n_cmp++; if (data_o !== prev) begin n_mis++; $display("FAIL stop_data_kept got %h want %h", data_o, prev); end
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL stop_busy got %b want 0", busy_o); end
    endtask

    task automatic test_reset_mid();
        int fe0;
        got_q.delete(); exp_q.delete();
        fe0 = ferr_cnt;
        dvsr_i = 11'd6;
        rx_i = 1'b0; repeat (112) step();
        rx_i = 1'b0; repeat (112) step();
        rx_i = 1'b1; repeat (112) step();
        rx_i = 1'b0; repeat (60) step();
        rst_i = 1'b1;
        rx_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_mis++; $display("FAIL rstmid_valid got %b want 0", valid_o); end
        n_cmp++; if (data_o !== 8'h00) begin n_mis++; $display("FAIL rstmid_data got %h want 00", data_o); end
        step();
        repeat (224) step();
        n_cmp++; if (got_q.size() !== 0 || ferr_cnt - fe0 !== 0) begin n_mis++; $display("FAIL rstmid_pulse got %0d valid %0d err want 0 0", got_q.size(), ferr_cnt - fe0); end
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        repeat (20) step();
        n_cmp++; if (got_q.size() !== 1) begin n_mis++; $display("FAIL rstmid_count got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== 8'h5A) begin n_mis++; $display("FAIL rstmid_data5a got %h want 5a", got_q[0]); end
        end
`ifdef RX_SERIAL_PARITY_EN
        got_q.delete();
        fe0 = ferr_cnt;
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        repeat (224) step();
        n_cmp++; if (ferr_cnt - fe0 !== 1) begin n_mis++; $display("FAIL parity_ferr got %0d want 1", ferr_cnt - fe0); end
        n_cmp++; if (got_q.size() !== 0) begin n_mis++; $display("FAIL parity_valid got %0d want 0", got_q.size()); end
`endif
    endtask

    task automatic test_random();
        int fe0;
        int ef0;
        bit stop_bit;
        bit par_flip;
        logic [7:0] d;
        got_q.delete(); exp_q.delete();
        fe0 = ferr_cnt;
        ef0 = exp_ferr;
        for (int f = 0; f < 8; f++) begin
            dvsr_i = 11'($urandom_range(0, 6));
            d = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            par_flip = ($urandom_range(0, 3) == 0);
            send_frame(d, stop_bit, par_flip, 1'b0);
            if (exp_ferr != ef0 + 0 && !(stop_bit
`ifdef RX_SERIAL_PARITY_EN
                && !par_flip
`endif
                )) begin
                repeat (2 * (int'(dvsr_i) + 1) * OVS) step();
            end else begin
                repeat ($urandom_range(0, 3)) step();
            end
        end
        repeat (40) step();
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL rand_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (ferr_cnt - fe0 !== exp_ferr - ef0) begin n_mis++; $display("FAIL rand_ferr got %0d want %0d", ferr_cnt - fe0, exp_ferr - ef0); end
    endtask

    task automatic test_pulse_rules();
        n_cmp++; if (both_cnt !== 0) begin n_mis++; $display("FAIL valid_and_err got %0d cycles want 0", both_cnt); end
        n_cmp++; if (dbl_cnt !== 0) begin n_mis++; $display("FAIL valid_width got %0d long pulses want 0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_loopback();
        test_glitch();
        test_stop_err();
        test_reset_mid();
        test_random();
        test_pulse_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
